// File: rtl/vga_sync_recover_if.sv
// Sync input pair and recovered timing outputs of the VGA sync receiver.
// The source side (master) drives the syncs; the receiver (slave) drives the rest.
interface vga_sync_recover_if;
  logic       h_sync;
  logic       v_sync;
  logic [9:0] x_loc;
  logic [9:0] y_loc;
  logic       video_on;
  logic       h_locked;
  logic       locked;
  logic [7:0] err_count;

  modport master (
    output h_sync, v_sync,
    input  x_loc, y_loc, video_on, h_locked, locked, err_count
  );

  modport slave (
    input  h_sync, v_sync,
    output x_loc, y_loc, video_on, h_locked, locked, err_count
  );
endinterface

// File: rtl/vga_sync_recover.sv
// Rebuilds pixel position and video_on from an active-low h/v sync pair and
// checks line/frame lengths, reporting lock and a saturating mismatch count.
//
// state  | meaning
// SEARCH | no line timing; waiting for the first h_sync falling edge
// TRACK  | edges seen, counting consecutive good line lengths
// LOCK   | line timing locked
module vga_sync_recover #(
  parameter int HD           = 640,
  parameter int HF           = 16,
  parameter int HR           = 96,
  parameter int HB           = 48,
  parameter int VD           = 480,
  parameter int VF           = 10,
  parameter int VR           = 2,
  parameter int VB           = 33,
  parameter int HLOCK_LINES  = 4,
  parameter int VLOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  vga_sync_recover_if.slave vga
);
  localparam int HTOTAL = HD + HF + HR + HB;
  localparam int HSTART = HD + HF;
  localparam int VTOTAL = VD + VF + VR + VB;
  localparam int VSTART = VD + VF;

  localparam logic [10:0] HPER_OK    = 11'(HTOTAL - 1);
  localparam logic [10:0] HPER_TO    = 11'(2 * HTOTAL);
  localparam logic [10:0] VPER_OK    = 11'(VTOTAL);
  localparam logic [9:0]  X_LAST     = 10'(HTOTAL - 1);
  localparam logic [9:0]  X_LOAD     = 10'(HSTART + 1);
  localparam logic [9:0]  Y_LAST     = 10'(VTOTAL - 1);
  localparam logic [9:0]  Y_LOAD     = 10'(VSTART);
  localparam logic [9:0]  X_VIS      = 10'(HD);
  localparam logic [9:0]  Y_VIS      = 10'(VD);
  localparam logic [3:0]  HGOOD_LOCK = 4'(HLOCK_LINES);
  localparam logic [3:0]  VGOOD_LOCK = 4'(VLOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCK} hstate_e;

  hstate_e     hstate_q, hstate_d;
  logic        h_prev_q, v_prev_q;
  logic [10:0] hper_q, hper_d;
  logic [3:0]  hgood_q, hgood_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [10:0] vper_q, vper_d;
  logic [3:0]  vgood_q, vgood_d;
  logic        v_locked_q, v_locked_d;
  logic        vstarted_q, vstarted_d;
  logic [7:0]  err_q, err_d;
  logic [8:0]  err_sum;
  logic        h_locked_q, locked_q, video_q;
  logic        h_fall, v_fall, h_err, v_err;

  assign h_fall = h_prev_q & ~vga.h_sync;
  assign v_fall = v_prev_q & ~vga.v_sync;

  always_comb begin
    if (h_fall)                hper_d = '0;
    else if (hper_q != 11'h7FF) hper_d = hper_q + 11'd1;
    else                       hper_d = hper_q;
  end

  always_comb begin
    hstate_d = hstate_q;
    hgood_d  = hgood_q;
    h_err    = 1'b0;
    unique case (hstate_q)
      SEARCH: begin
        if (h_fall) begin
          hstate_d = TRACK;
          hgood_d  = '0;
        end
      end
      TRACK: begin
        if (h_fall) begin
          if (hper_q == HPER_OK) begin
            hgood_d = hgood_q + 4'd1;
            if (hgood_q == HGOOD_LOCK - 4'd1) begin
              hstate_d = LOCK;
              hgood_d  = '0;
            end
          end else begin
            hgood_d = '0;
            h_err   = 1'b1;
          end
        end else if (hper_d >= HPER_TO) begin
          hstate_d = SEARCH;
        end
      end
      LOCK: begin
        if (h_fall) begin
          if (hper_q != HPER_OK) begin
            hstate_d = TRACK;
            hgood_d  = '0;
            h_err    = 1'b1;
          end
        end else if (hper_d >= HPER_TO) begin
          hstate_d = SEARCH;
        end
      end
      default: hstate_d = SEARCH;
    endcase
  end

  // v_fall wins over a coincident x wrap so the frame realigns cleanly.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (hstate_d == SEARCH) begin
      x_d = '0;
      y_d = '0;
    end else begin
      if (h_fall)             x_d = X_LOAD;
      else if (x_q == X_LAST) x_d = '0;
      else                    x_d = x_q + 10'd1;
      if (v_fall)
        y_d = Y_LOAD;
      else if (!h_fall && x_q == X_LAST)
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
    end
  end

  always_comb begin
    vper_d     = vper_q;
    vgood_d    = vgood_q;
    v_locked_d = v_locked_q;
    vstarted_d = vstarted_q;
    v_err      = 1'b0;
    if (v_fall) begin
      vper_d     = '0;
      vstarted_d = 1'b1;
      if (h_locked_q && vstarted_q) begin
        if (vper_q == VPER_OK) begin
          if (vgood_q != VGOOD_LOCK) vgood_d = vgood_q + 4'd1;
          if (vgood_q >= VGOOD_LOCK - 4'd1) v_locked_d = 1'b1;
        end else begin
          v_locked_d = 1'b0;
          vgood_d    = '0;
          v_err      = 1'b1;
        end
      end
    end else if (h_fall && vper_q != 11'h7FF) begin
      vper_d = vper_q + 11'd1;
    end
    if (hstate_d != LOCK) begin
      v_locked_d = 1'b0;
      vgood_d    = '0;
    end
    if (hstate_d == SEARCH) vstarted_d = 1'b0;
  end

  always_comb begin
    err_sum = {1'b0, err_q} + {8'b0, h_err} + {8'b0, v_err};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hstate_q   <= SEARCH;
      h_prev_q   <= 1'b1;
      v_prev_q   <= 1'b1;
      hper_q     <= '0;
      hgood_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      vper_q     <= '0;
      vgood_q    <= '0;
      v_locked_q <= 1'b0;
      vstarted_q <= 1'b0;
      err_q      <= '0;
      h_locked_q <= 1'b0;
      locked_q   <= 1'b0;
      video_q    <= 1'b0;
    end else begin
      hstate_q   <= hstate_d;
      h_prev_q   <= vga.h_sync;
      v_prev_q   <= vga.v_sync;
      hper_q     <= hper_d;
      hgood_q    <= hgood_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vper_q     <= vper_d;
      vgood_q    <= vgood_d;
      v_locked_q <= v_locked_d;
      vstarted_q <= vstarted_d;
      err_q      <= err_d;
      h_locked_q <= (hstate_d == LOCK);
      locked_q   <= (hstate_d == LOCK) && v_locked_d;
      video_q    <= (hstate_d == LOCK) && v_locked_d && (x_d < X_VIS) && (y_d < Y_VIS);
    end
  end

  assign vga.x_loc     = x_q;
  assign vga.y_loc     = y_q;
  assign vga.video_on  = video_q;
  assign vga.h_locked  = h_locked_q;
  assign vga.locked    = locked_q;
  assign vga.err_count = err_q;
endmodule

// File: tb/tb_vga_sync_recover.sv
// Bench for vga_sync_recover on a scaled-down raster (25x15 totals) so that
// several frames, timeouts and error saturation fit in a short run.
module tb_vga_sync_recover;
  localparam int HD = 16, HF = 2, HR = 4, HB = 3;
  localparam int VD = 8,  VF = 2, VR = 2, VB = 3;
  localparam int HTOTAL = HD + HF + HR + HB;
  localparam int HSTART = HD + HF;
  localparam int VTOTAL = VD + VF + VR + VB;
  localparam int VSTART = VD + VF;
  localparam int GUARD  = 10000;

  logic clk = 1'b0;
  logic reset;
  vga_sync_recover_if vif ();

  vga_sync_recover #(
    .HD(HD), .HF(HF), .HR(HR), .HB(HB),
    .VD(VD), .VF(VF), .VR(VR), .VB(VB),
    .HLOCK_LINES(4), .VLOCK_FRAMES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vga  (vif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // source raster model: counts and registered syncs
  int hc, vc, hlen, vlen, hlen_req, vlen_req, hlen_nom;
  bit hold, v_early, sb_en;
  int nfall, nvf;
  logic [21:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] exp_pix(input int h, input int v);
    return {1'b1, (h < HD && v < VD), 10'(v), 10'(h)};
  endfunction

  task automatic step();
    logic hs_n, vs_n;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0)
      check("pix", {10'b0, vif.locked, vif.video_on, vif.y_loc, vif.x_loc}, {10'b0, sb_q.pop_front()});
    hs_n = !(hc >= HSTART && hc < HSTART + HR);
    vs_n = !(vc >= VSTART && vc < VSTART + VR);
    if (hc == hlen - 1) begin
      hc = 0;
      hlen = hlen_req;
      hlen_req = hlen_nom;
      if (vc == vlen - 1) begin
        vc = 0;
        vlen = vlen_req;
        vlen_req = VTOTAL;
      end else vc++;
    end else hc++;
    if (v_early) vs_n = !(vc >= VSTART && vc < VSTART + VR);
    if (hold) begin
      hs_n = 1'b1;
      vs_n = 1'b1;
    end
    if (vif.h_sync && !hs_n) nfall++;
    if (vif.v_sync && !vs_n) nvf++;
    vif.h_sync = hs_n;
    vif.v_sync = vs_n;
    if (sb_en) sb_q.push_back(exp_pix(hc, vc));
  endtask

  task automatic run_falls(input int target);
    int g = 0;
    while (nfall < target && g < GUARD) begin step(); g++; end
    if (nfall != target) check("timeout_hfall", 32'(nfall), 32'(target));
  endtask

  task automatic run_vfalls(input int target);
    int g = 0;
    while (nvf < target && g < GUARD) begin step(); g++; end
    if (nvf != target) check("timeout_vfall", 32'(nvf), 32'(target));
  endtask

  task automatic run_to(input int h, input int v);
    int g = 0;
    step();
    while (!(hc == h && (v < 0 || vc == v)) && g < GUARD) begin step(); g++; end
    if (g >= GUARD) check("timeout_pos", 32'(hc), 32'(h));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"},   32'(vif.x_loc), 32'd0);
    check({tag, "_y"},   32'(vif.y_loc), 32'd0);
    check({tag, "_vid"}, 32'(vif.video_on), 32'd0);
    check({tag, "_hl"},  32'(vif.h_locked), 32'd0);
    check({tag, "_lk"},  32'(vif.locked), 32'd0);
    check({tag, "_err"}, 32'(vif.err_count), 32'd0);
  endtask

  initial begin
    int n0, nv0;
    reset = 1'b1;
    vif.h_sync = 1'b1;
    vif.v_sync = 1'b1;
    hc = 0; vc = 0;
    hlen = HTOTAL; hlen_req = HTOTAL; hlen_nom = HTOTAL;
    vlen = VTOTAL; vlen_req = VTOTAL;
    hold = 1'b0; v_early = 1'b0; sb_en = 1'b0;
    nfall = 0; nvf = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // acquisition: h lock on the 5th edge, full lock after two good frames
    run_falls(4); step(); check("hlock_4th", 32'(vif.h_locked), 32'd0);
    run_falls(5); step(); check("hlock_5th", 32'(vif.h_locked), 32'd1);
    run_vfalls(2); step(); check("lock_vf2", 32'(vif.locked), 32'd0);
    run_vfalls(3); step(); check("lock_vf3", 32'(vif.locked), 32'd1);

    // one full locked frame against the source raster, delayed one cycle
    run_to(0, 0);
    sb_en = 1'b1;
    repeat (HTOTAL * VTOTAL) step();
    sb_en = 1'b0;
    step();
    check("err_nominal", 32'(vif.err_count), 32'd0);

    // one long line while locked
    run_to(0, 0);
    hlen_req = HTOTAL + 1;
    n0 = nfall; nv0 = nvf;
    run_falls(n0 + 2); step(); check("long_pre_hl", 32'(vif.h_locked), 32'd1);
    run_falls(n0 + 3); step();
    check("long_hl", 32'(vif.h_locked), 32'd0);
    check("long_lk", 32'(vif.locked), 32'd0);
    check("long_err", 32'(vif.err_count), 32'd1);
    run_falls(n0 + 6); step(); check("relock_3", 32'(vif.h_locked), 32'd0);
    run_falls(n0 + 7); step(); check("relock_4", 32'(vif.h_locked), 32'd1);
    run_vfalls(nv0 + 1); step(); check("relock_vf1", 32'(vif.locked), 32'd0);
    run_vfalls(nv0 + 2); step(); check("relock_vf2", 32'(vif.locked), 32'd1);

    // short frame; its closing v_fall lands on the x wrap
    run_to(0, 0);
    vlen_req = VTOTAL - 1;
    nv0 = nvf;
    run_vfalls(nv0 + 2); step(); check("short_pre_lk", 32'(vif.locked), 32'd1);
    v_early = 1'b1;
    run_vfalls(nv0 + 3); step();
    check("short_y", 32'(vif.y_loc), 32'(VSTART));
    check("short_x", 32'(vif.x_loc), 32'd0);
    check("short_lk", 32'(vif.locked), 32'd0);
    check("short_hl", 32'(vif.h_locked), 32'd1);
    check("short_err", 32'(vif.err_count), 32'd2);
    v_early = 1'b0;

    // sync loss: timeout at twice the line length
    n0 = nfall;
    run_falls(n0 + 1);
    hold = 1'b1;
    hlen_nom = HTOTAL - 1;
    hlen_req = HTOTAL - 1;
    repeat (2 * HTOTAL) step();
    check("hold_pre_hl", 32'(vif.h_locked), 32'd1);
    step();
    check("hold_hl", 32'(vif.h_locked), 32'd0);
    check("hold_x", 32'(vif.x_loc), 32'd0);
    check("hold_y", 32'(vif.y_loc), 32'd0);
    check("hold_vid", 32'(vif.video_on), 32'd0);
    check("hold_err", 32'(vif.err_count), 32'd2);

    // every line one cycle short: error count climbs and saturates
    run_to(0, -1);
    hold = 1'b0;
    n0 = nfall;
    run_falls(n0 + 11); step(); check("bad_err10", 32'(vif.err_count), 32'd12);
    run_falls(n0 + 301); step(); check("bad_sat", 32'(vif.err_count), 32'd255);
    run_falls(n0 + 311); step();
    check("bad_sat_hold", 32'(vif.err_count), 32'd255);
    check("bad_hl", 32'(vif.h_locked), 32'd0);

    // asynchronous reset mid-line
    hlen_nom = HTOTAL;
    hlen_req = HTOTAL;
    run_falls(nfall + 3);
    run_to(12, -1);
    check("prerst_x", 32'(vif.x_loc), 32'd11);
    #2 reset = 1'b1;
    #1 check_all_zero("midrst");
    hold = 1'b1;
    step();
    #3 reset = 1'b0;
    repeat (3 * HTOTAL) step();
    check_all_zero("idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
